// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the instruction memory and queues
// each fetched {pc, instruction} pair in a 2-entry buffer toward decode.
module instr_fetch_ctrl #(
   parameter int ADDR_SIZE = 8,
   parameter int INSTR_WIDTH = 32,
   parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   redirect_valid,
   input  logic [ADDR_SIZE-1:0]   redirect_pc,
   output logic [ADDR_SIZE-1:0]   imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_instr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [ADDR_SIZE-1:0]   out_pc
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state;
   state_t                 state_next;
   logic [ADDR_SIZE-1:0]   pc;
   logic [1:0]             count;
   logic [ADDR_SIZE-1:0]   head_pc;
   logic [INSTR_WIDTH-1:0] head_instr;
   logic [ADDR_SIZE-1:0]   tail_pc;
   logic [INSTR_WIDTH-1:0] tail_instr;
   logic                   pop;
   logic                   push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // en alone picks the next state; a redirect never blocks the transition
   always_comb begin
      state_next = state;
      pop        = out_valid & out_ready;
      push       = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_next = RUN;
         end
         RUN: begin
            push = !redirect_valid & ((count != 2'd2) | pop);
            if (!en) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Slot "head" always holds the oldest entry so out_* come straight from flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         count      <= 2'd0;
         head_pc    <= '0;
         head_instr <= '0;
         tail_pc    <= '0;
         tail_instr <= '0;
      end else if (redirect_valid) begin
         pc    <= redirect_pc;
         count <= 2'd0;
      end else begin
         if (push) pc <= pc + 1'b1;
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_pc    <= pc;
                  head_instr <= imem_instr;
               end else begin
                  tail_pc    <= pc;
                  tail_instr <= imem_instr;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_pc    <= tail_pc;
               head_instr <= tail_instr;
               count      <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head_pc    <= pc;
                  head_instr <= imem_instr;
               end else begin
                  head_pc    <= tail_pc;
                  head_instr <= tail_instr;
                  tail_pc    <= pc;
                  tail_instr <= imem_instr;
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_addr = pc;
   assign out_valid = (count != 2'd0);
   assign out_instr = head_instr;
   assign out_pc    = head_pc;

   // Occupancy bound and head stability under back-pressure
   a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count <= 2'd2);
   a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !redirect_valid) |=>
         (out_valid && $stable(out_instr) && $stable(out_pc)));

endmodule
